// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle core: opcodes, instruction field positions,
// FSM states and the ALU operation set.
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_MOVI = 4'h6;
  localparam logic [3:0] OP_LDR  = 4'h7;
  localparam logic [3:0] OP_STR  = 4'h8;
  localparam logic [3:0] OP_B    = 4'h9;
  localparam logic [3:0] OP_BZ   = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hB;

  localparam int OP_LSB  = 12;
  localparam int RD_LSB  = 10;
  localparam int RS_LSB  = 8;
  localparam int IMM_LSB = 0;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_PASS
  } alu_op_t;

  // Anything that is not a two-operand ALU op simply forwards operand B.
  function automatic alu_op_t alu_op_of(input logic [3:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_XOR:  return ALU_XOR;
      default: return ALU_PASS;
    endcase
  endfunction

endpackage

// File: rtl/cpu_core_mc_if.sv
// Shared fetch/data memory port: single outstanding request, completed by ack.
interface cpu_core_mc_if #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_wdata;
  logic              mem_ack;
  logic [DWIDTH-1:0] mem_rdata;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_ack, mem_rdata);
  modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_ack, mem_rdata);
endinterface

// File: rtl/cpu_alu.sv
// Combinational ALU, wraps mod 2^DWIDTH; zero_o flags an all-zero result.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DWIDTH = 16
) (
  input  logic [DWIDTH-1:0] a_i,
  input  logic [DWIDTH-1:0] b_i,
  input  alu_op_t           op_i,
  output logic [DWIDTH-1:0] y_o,
  output logic              zero_o
);

  always_comb begin
    y_o = b_i;
    case (op_i)
      ALU_ADD: y_o = a_i + b_i;
      ALU_SUB: y_o = a_i - b_i;
      ALU_AND: y_o = a_i & b_i;
      ALU_OR:  y_o = a_i | b_i;
      ALU_XOR: y_o = a_i ^ b_i;
      default: y_o = b_i;
    endcase
  end

  assign zero_o = (y_o == '0);

endmodule

// File: rtl/cpu_core_mc.sv
// Multi-cycle 16-bit-ISA core with width-generic datapath and one shared req/ack memory port.
// run is honoured only at instruction boundaries; HALT is terminal until reset.
module cpu_core_mc
  import cpu_pkg::*;
#(
  parameter int                 DWIDTH   = 16,
  parameter int                 AWIDTH   = 16,
  parameter logic [AWIDTH-1:0]  RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  cpu_core_mc_if.master      mem,
  output logic [AWIDTH-1:0]  pc_out,
  output logic               halted,
  output logic               illegal
);

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic [DWIDTH-1:0] regs_q [4];
  logic [DWIDTH-1:0] regs_d [4];
  logic [DWIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic              z_q, z_d;

  logic [3:0]        op;
  logic [1:0]        rd, rs;
  logic [7:0]        imm;
  logic [AWIDTH-1:0] br_target;
  logic              mem_we;
  state_t            boundary;

  assign op        = ir_q[OP_LSB +: 4];
  assign rd        = ir_q[RD_LSB +: 2];
  assign rs        = ir_q[RS_LSB +: 2];
  assign imm       = ir_q[IMM_LSB +: 8];
  assign br_target = pc_q + AWIDTH'($signed(imm));
  assign boundary  = run ? S_FETCH : S_IDLE;

  // In WB the ALU passes the result through so its zero detect drives the Z flag.
  alu_op_t           alu_op;
  logic [DWIDTH-1:0] alu_b, alu_y;
  logic              alu_zero;

  assign alu_op = (state_q == S_WB) ? ALU_PASS : alu_op_of(op);
  assign alu_b  = (state_q == S_WB) ? res_q
                : (op == OP_MOVI)   ? DWIDTH'(imm) : b_q;

  cpu_alu #(.DWIDTH(DWIDTH)) u_alu (
    .a_i    (a_q),
    .b_i    (alu_b),
    .op_i   (alu_op),
    .y_o    (alu_y),
    .zero_o (alu_zero)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    z_d     = z_q;
    regs_d  = regs_q;
    case (state_q)
      S_IDLE: if (run) state_d = S_FETCH;
      S_FETCH: begin
        if (mem.mem_ack) begin
          ir_d    = mem.mem_rdata[15:0];
          pc_d    = pc_q + AWIDTH'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d     = regs_q[rd];
        b_d     = regs_q[rs];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        res_d = alu_y;
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MOVI: state_d = S_WB;
          OP_LDR, OP_STR: state_d = S_MEM;
          OP_B: begin
            pc_d    = br_target;
            state_d = boundary;
          end
          OP_BZ: begin
            if (z_q) pc_d = br_target;
            state_d = boundary;
          end
          OP_HALT: state_d = S_HALT;
          default: state_d = boundary;
        endcase
      end
      S_MEM: begin
        if (mem.mem_ack) begin
          if (op == OP_LDR) begin
            res_d   = mem.mem_rdata;
            state_d = S_WB;
          end else begin
            state_d = boundary;
          end
        end
      end
      S_WB: begin
        regs_d[rd] = res_q;
        z_d        = alu_zero;
        state_d    = boundary;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      regs_q  <= '{default: '0};
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      regs_q  <= regs_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      z_q     <= z_d;
    end
  end

  // Port drive depends only on registered state, so it holds steady across wait states.
  assign mem_we        = (state_q == S_MEM) && (op == OP_STR);
  assign mem.mem_req   = (state_q == S_FETCH) || (state_q == S_MEM);
  assign mem.mem_we    = mem_we;
  assign mem.mem_addr  = (state_q == S_MEM) ? AWIDTH'(imm) : pc_q;
  assign mem.mem_wdata = mem_we ? a_q : '0;

  assign pc_out  = pc_q;
  assign halted  = (state_q == S_HALT);
  assign illegal = (state_q == S_EXEC) && (op >= 4'hC);

endmodule

// File: tb/tb_cpu_core_mc.sv
// Self-checking bench: memory responder with wait states, store scoreboard, scenario tasks.
module tb_cpu_core_mc;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [15:0] pc_out;
  logic        halted;
  logic        illegal;

  always #5 clk = ~clk;

  cpu_core_mc_if #(.DWIDTH(16), .AWIDTH(16)) ifc ();

  cpu_core_mc #(.DWIDTH(16), .AWIDTH(16), .RESET_PC(16'h0000)) dut (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .mem     (ifc.master),
    .pc_out  (pc_out),
    .halted  (halted),
    .illegal (illegal)
  );

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } st_t;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] mem_arr [0:255];
  bit          auto_mem = 1'b1;
  int          wait_states = 0;
  logic        man_ack = 1'b0;
  logic [15:0] man_rdata = '0;
  bit          unstable = 1'b0;
  st_t         exp_q [$];
  st_t         obs_q [$];

  function automatic logic [15:0] ins(input logic [3:0] op, input logic [1:0] rd,
                                      input logic [1:0] rs, input logic [7:0] imm);
    return {op, rd, rs, imm};
  endfunction

  // Memory responder: decides ack/rdata on the falling edge for the next rising edge.
  initial begin
    int          wcnt;
    logic [15:0] cap_a, cap_d;
    logic        cap_we, ack_v;
    logic [15:0] rd_v;
    wcnt = 0; cap_a = '0; cap_d = '0; cap_we = 1'b0;
    ifc.mem_ack = 1'b0;
    ifc.mem_rdata = '0;
    forever begin
      @(negedge clk);
      ack_v = 1'b0;
      rd_v  = '0;
      if (!auto_mem) begin
        ack_v = man_ack;
        rd_v  = man_rdata;
        wcnt  = 0;
      end else if (ifc.mem_req) begin
        if (wcnt == 0) begin
          cap_a = ifc.mem_addr; cap_d = ifc.mem_wdata; cap_we = ifc.mem_we;
        end else if (ifc.mem_addr !== cap_a || ifc.mem_wdata !== cap_d || ifc.mem_we !== cap_we) begin
          unstable = 1'b1;
        end
        if (wcnt == wait_states) begin
          ack_v = 1'b1;
          wcnt  = 0;
          if (ifc.mem_we) begin
            mem_arr[ifc.mem_addr[7:0]] = ifc.mem_wdata;
            obs_q.push_back('{addr: ifc.mem_addr, data: ifc.mem_wdata});
          end else begin
            rd_v = mem_arr[ifc.mem_addr[7:0]];
          end
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
      ifc.mem_ack   = ack_v;
      ifc.mem_rdata = rd_v;
    end
  end

  task automatic clear_tb();
    for (int i = 0; i < 256; i++) mem_arr[i] = '0;
    exp_q.delete();
    obs_q.delete();
    unstable = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_prog(input int budget, output int cycles, output int ill_cnt);
    run = 1'b1;
    cycles = 0;
    ill_cnt = 0;
    while (1) begin
      @(posedge clk);
      #1;
      cycles++;
      if (illegal) ill_cnt++;
      if (halted) break;
      if (cycles >= budget) begin
        checks++; errors++;
        $display("FAIL run_timeout: no halt after %0d cycles", cycles);
        break;
      end
    end
    run = 1'b0;
  endtask

  task automatic check_stores(input string name);
    st_t e, o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL %s store_missing: got none, want addr=%h data=%h", name, e.addr, e.data);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL %s store: got addr=%h data=%h, want addr=%h data=%h",
                   name, o.addr, o.data, e.addr, e.data);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL %s extra_store: got %0d unexpected stores, want 0", name, obs_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    run = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ifc.mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", ifc.mem_req); end
    checks++; if (pc_out !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h want 0000", pc_out); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b want 0", illegal); end
    rst = 1'b0;
  endtask

  task automatic test_alu_halt();
    int cyc, ill;
    clear_tb();
    mem_arr[0] = ins(OP_MOVI, 2'd1, 2'd0, 8'h05);
    mem_arr[1] = ins(OP_MOVI, 2'd2, 2'd0, 8'h03);
    mem_arr[2] = ins(OP_SUB,  2'd1, 2'd2, 8'h00);
    mem_arr[3] = ins(OP_STR,  2'd1, 2'd0, 8'h40);
    mem_arr[4] = ins(OP_BZ,   2'd0, 2'd0, 8'h01);
    mem_arr[5] = ins(OP_HALT, 2'd0, 2'd0, 8'h00);
    mem_arr[6] = ins(OP_STR,  2'd2, 2'd0, 8'h41);
    exp_q.push_back('{addr: 16'h0040, data: 16'h0002});
    do_reset();
    run_prog(200, cyc, ill);
    checks++; if (cyc != 23) begin errors++; $display("FAIL alu_cycles: got %0d want 23", cyc); end
    checks++; if (pc_out !== 16'h0006) begin errors++; $display("FAIL alu_pc: got %h want 0006", pc_out); end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL alu_halted: got %b want 1", halted); end
    check_stores("alu");
  endtask

  task automatic test_add_wrap_branch();
    int cyc, ill;
    clear_tb();
    mem_arr[8'h30] = 16'hFFFF;
    mem_arr[0] = ins(OP_LDR,  2'd0, 2'd0, 8'h30);
    mem_arr[1] = ins(OP_MOVI, 2'd1, 2'd0, 8'h01);
    mem_arr[2] = ins(OP_ADD,  2'd0, 2'd1, 8'h00);
    mem_arr[3] = ins(OP_BZ,   2'd0, 2'd0, 8'h02);
    mem_arr[4] = ins(OP_STR,  2'd1, 2'd0, 8'h41);
    mem_arr[5] = ins(OP_HALT, 2'd0, 2'd0, 8'h00);
    mem_arr[6] = ins(OP_STR,  2'd0, 2'd0, 8'h42);
    mem_arr[7] = ins(OP_B,    2'd0, 2'd0, 8'hFC);
    exp_q.push_back('{addr: 16'h0042, data: 16'h0000});
    exp_q.push_back('{addr: 16'h0041, data: 16'h0001});
    do_reset();
    run_prog(300, cyc, ill);
    checks++; if (pc_out !== 16'h0006) begin errors++; $display("FAIL wrap_pc: got %h want 0006", pc_out); end
    checks++; if (ill != 0) begin errors++; $display("FAIL wrap_illegal: got %0d pulses want 0", ill); end
    check_stores("wrap");
  endtask

  task automatic test_wait_states();
    int cyc, ill;
    clear_tb();
    mem_arr[8'h20] = 16'h1234;
    mem_arr[0] = ins(OP_MOVI, 2'd3, 2'd0, 8'hA5);
    mem_arr[1] = ins(OP_STR,  2'd3, 2'd0, 8'h20);
    mem_arr[2] = ins(OP_LDR,  2'd0, 2'd0, 8'h20);
    mem_arr[3] = ins(OP_STR,  2'd0, 2'd0, 8'h50);
    mem_arr[4] = ins(OP_HALT, 2'd0, 2'd0, 8'h00);
    exp_q.push_back('{addr: 16'h0020, data: 16'h00A5});
    exp_q.push_back('{addr: 16'h0050, data: 16'h00A5});
    do_reset();
    wait_states = 3;
    run_prog(400, cyc, ill);
    wait_states = 0;
    checks++; if (cyc != 45) begin errors++; $display("FAIL wait_cycles: got %0d want 45", cyc); end
    checks++; if (unstable !== 1'b0) begin errors++; $display("FAIL wait_stable: got %b want 0", unstable); end
    checks++; if (pc_out !== 16'h0005) begin errors++; $display("FAIL wait_pc: got %h want 0005", pc_out); end
    check_stores("wait");
  endtask

  task automatic test_run_gate();
    int cyc, ill, req_hi;
    clear_tb();
    mem_arr[0] = ins(OP_MOVI, 2'd0, 2'd0, 8'h07);
    mem_arr[1] = ins(OP_MOVI, 2'd1, 2'd0, 8'h02);
    mem_arr[2] = ins(OP_ADD,  2'd0, 2'd1, 8'h00);
    mem_arr[3] = ins(OP_STR,  2'd0, 2'd0, 8'h60);
    mem_arr[4] = ins(OP_HALT, 2'd0, 2'd0, 8'h00);
    exp_q.push_back('{addr: 16'h0060, data: 16'h0009});
    do_reset();
    run = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    run = 1'b0;
    checks++; if (pc_out !== 16'h0003) begin errors++; $display("FAIL gate_pc_exec: got %h want 0003", pc_out); end
    req_hi = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (ifc.mem_req) req_hi++;
    end
    checks++; if (req_hi != 0) begin errors++; $display("FAIL gate_idle_req: got %0d req cycles want 0", req_hi); end
    checks++; if (pc_out !== 16'h0003) begin errors++; $display("FAIL gate_pc_idle: got %h want 0003", pc_out); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL gate_halted: got %b want 0", halted); end
    run_prog(100, cyc, ill);
    checks++; if (pc_out !== 16'h0005) begin errors++; $display("FAIL gate_pc_end: got %h want 0005", pc_out); end
    check_stores("gate");
  endtask

  task automatic test_illegal();
    int cyc, ill;
    clear_tb();
    mem_arr[0] = ins(OP_MOVI, 2'd2, 2'd0, 8'h11);
    mem_arr[1] = ins(4'hD,    2'd2, 2'd1, 8'hFF);
    mem_arr[2] = ins(OP_STR,  2'd2, 2'd0, 8'h70);
    mem_arr[3] = ins(OP_HALT, 2'd0, 2'd0, 8'h00);
    exp_q.push_back('{addr: 16'h0070, data: 16'h0011});
    do_reset();
    run_prog(100, cyc, ill);
    checks++; if (ill != 1) begin errors++; $display("FAIL illegal_pulses: got %0d want 1", ill); end
    checks++; if (pc_out !== 16'h0004) begin errors++; $display("FAIL illegal_pc: got %h want 0004", pc_out); end
    check_stores("illegal");
  endtask

  task automatic test_reset_mid_fetch();
    clear_tb();
    auto_mem = 1'b0;
    man_ack = 1'b0;
    do_reset();
    run = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (ifc.mem_req !== 1'b1 || ifc.mem_addr !== 16'h0000) begin
      errors++; $display("FAIL rmf_fetch0: got req=%b addr=%h want req=1 addr=0000", ifc.mem_req, ifc.mem_addr);
    end
    man_rdata = ins(OP_MOVI, 2'd0, 2'd0, 8'h01);
    man_ack = 1'b1;
    @(posedge clk);
    #1;
    man_ack = 1'b0;
    checks++; if (pc_out !== 16'h0001) begin errors++; $display("FAIL rmf_pc1: got %h want 0001", pc_out); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ifc.mem_req !== 1'b1 || ifc.mem_addr !== 16'h0001) begin
      errors++; $display("FAIL rmf_fetch1: got req=%b addr=%h want req=1 addr=0001", ifc.mem_req, ifc.mem_addr);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    man_rdata = ins(OP_HALT, 2'd0, 2'd0, 8'h00);
    man_ack = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (ifc.mem_req !== 1'b0) begin errors++; $display("FAIL rmf_req_after_rst: got %b want 0", ifc.mem_req); end
    checks++; if (pc_out !== 16'h0000) begin errors++; $display("FAIL rmf_pc_after_rst: got %h want 0000", pc_out); end
    rst = 1'b0;
    run = 1'b0;
    @(posedge clk);
    #1;
    man_ack = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (ifc.mem_req !== 1'b0 || pc_out !== 16'h0000 || halted !== 1'b0) begin
      errors++; $display("FAIL rmf_late_ack: got req=%b pc=%h halted=%b want 0/0000/0", ifc.mem_req, pc_out, halted);
    end
    run = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (ifc.mem_req !== 1'b1 || ifc.mem_addr !== 16'h0000) begin
      errors++; $display("FAIL rmf_restart: got req=%b addr=%h want req=1 addr=0000", ifc.mem_req, ifc.mem_addr);
    end
    run = 1'b0;
    auto_mem = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    run = 1'b0;
    test_reset();
    test_alu_halt();
    test_add_wrap_branch();
    test_wait_states();
    test_run_gate();
    test_illegal();
    test_reset_mid_fetch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
